// File: rtl/csr_commit_unit_pkg.sv
// Shared constants for the WB-stage CSR commit unit: op encodings, exception codes,
// FSM state type and a small op-class helper.
package csr_commit_unit_pkg;

    localparam int unsigned CSR_NUM_WIDTH = 14;

    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_CSRRD   = 3'd1;
    localparam logic [2:0] OP_CSRWR   = 3'd2;
    localparam logic [2:0] OP_CSRXCHG = 3'd3;
    localparam logic [2:0] OP_ERTN    = 3'd4;
    localparam logic [2:0] OP_SYSCALL = 3'd5;
    localparam logic [2:0] OP_BREAK   = 3'd6;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_IPE = 6'h0E;

    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;

    typedef enum logic {
        StIdle,
        StFlush
    } state_e;

    function automatic logic is_csr_op(input logic [2:0] op);
        return (op == OP_CSRRD) || (op == OP_CSRWR) || (op == OP_CSRXCHG);
    endfunction

endpackage

// File: rtl/csr_commit_unit_ex_resolve.sv
// Priority resolution of the final exception for the instruction in WB.
// Purely combinational; validity gating is left to the caller.
module csr_commit_unit_ex_resolve
    import csr_commit_unit_pkg::*;
(
    input  logic       has_int_i,
    input  logic       ex_i,
    input  logic [5:0] ecode_i,
    input  logic [8:0] esubcode_i,
    input  logic [2:0] op_i,
    input  logic [1:0] plv_i,
    output logic       ex_o,
    output logic [5:0] ecode_o,
    output logic [8:0] esubcode_o
);

    logic priv_violation;

    assign priv_violation = (is_csr_op(op_i) || (op_i == OP_ERTN)) && (plv_i != 2'd0);

    always_comb begin
        ex_o       = 1'b1;
        ecode_o    = ECODE_INT;
        esubcode_o = ESUBCODE_ADEF;
        if (has_int_i) begin
            ecode_o = ECODE_INT;
        end else if (ex_i) begin
            ecode_o    = ecode_i;
            esubcode_o = esubcode_i;
        end else if (priv_violation) begin
            ecode_o = ECODE_IPE;
        end else if (op_i == OP_SYSCALL) begin
            ecode_o = ECODE_SYS;
        end else if (op_i == OP_BREAK) begin
            ecode_o = ECODE_BRK;
        end else begin
            ex_o = 1'b0;
        end
    end

endmodule

// File: rtl/csr_commit_unit.sv
// WB-stage CSR initiator: commits one instruction per cycle to the CSR file and GPRs,
// and holds a fetch redirect after any exception or ERTN until fetch acknowledges it.
module csr_commit_unit #(
    parameter int unsigned CSR_NUM_WIDTH = csr_commit_unit_pkg::CSR_NUM_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [2:0]               in_op,
    input  logic [CSR_NUM_WIDTH-1:0] in_csr_num,
    input  logic [31:0]              in_rj_value,
    input  logic [31:0]              in_rd_value,
    input  logic [4:0]               in_dest,
    input  logic [31:0]              in_result,
    input  logic                     in_ex,
    input  logic [5:0]               in_ecode,
    input  logic [8:0]               in_esubcode,
    input  logic [31:0]              in_vaddr,
    output logic                     csr_re,
    output logic                     csr_we,
    output logic [CSR_NUM_WIDTH-1:0] csr_num,
    output logic [31:0]              csr_wmask,
    output logic [31:0]              csr_wvalue,
    input  logic [31:0]              csr_rvalue,
    input  logic                     has_int,
    input  logic [1:0]               csr_plv,
    input  logic [31:0]              ex_entry,
    output logic                     ertn_flush,
    output logic                     wb_ex_with_ertn,
    output logic [31:0]              wb_pc,
    output logic [31:0]              wb_vaddr,
    output logic [5:0]               wb_ecode,
    output logic [8:0]               wb_esubcode,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    input  logic                     redirect_ready
);

    import csr_commit_unit_pkg::*;

    state_e state_q, state_d;
    logic   wb_valid_q, wb_valid_d;
    logic   [31:0] redirect_pc_q, redirect_pc_d;

    logic   [31:0]              wb_pc_q;
    logic   [2:0]               wb_op_q;
    logic   [CSR_NUM_WIDTH-1:0] wb_csr_num_q;
    logic   [31:0]              wb_rj_q;
    logic   [31:0]              wb_rd_q;
    logic   [4:0]               wb_dest_q;
    logic   [31:0]              wb_result_q;
    logic                       wb_ex_q;
    logic   [5:0]               wb_ecode_q;
    logic   [8:0]               wb_esubcode_q;
    logic   [31:0]              wb_vaddr_q;

    logic       accept;
    logic       res_ex;
    logic [5:0] res_ecode;
    logic [8:0] res_esubcode;
    logic       commit_ex;
    logic       wb_is_csr;
    logic       wb_writes_gpr_op;

    csr_commit_unit_ex_resolve u_ex_resolve (
        .has_int_i  (has_int),
        .ex_i       (wb_ex_q),
        .ecode_i    (wb_ecode_q),
        .esubcode_i (wb_esubcode_q),
        .op_i       (wb_op_q),
        .plv_i      (csr_plv),
        .ex_o       (res_ex),
        .ecode_o    (res_ecode),
        .esubcode_o (res_esubcode)
    );

    // The instruction behind a committing exception/ERTN is already stale, so it is
    // dropped on the same edge that enters FLUSH.
    assign accept     = in_valid && (state_q == StIdle) && !wb_ex_with_ertn;
    assign wb_valid_d = accept;

    assign commit_ex        = wb_valid_q && res_ex;
    assign wb_is_csr        = is_csr_op(wb_op_q);
    assign wb_writes_gpr_op = !((wb_op_q == OP_ERTN) || (wb_op_q == OP_SYSCALL)
                                || (wb_op_q == OP_BREAK));

    always_comb begin
        ertn_flush      = wb_valid_q && !res_ex && (wb_op_q == OP_ERTN);
        wb_ex_with_ertn = commit_ex || ertn_flush;
        csr_re          = wb_valid_q && !res_ex && wb_is_csr;
        csr_we          = wb_valid_q && !res_ex
                          && ((wb_op_q == OP_CSRWR) || (wb_op_q == OP_CSRXCHG));
        csr_num         = wb_csr_num_q;
        csr_wmask       = (wb_op_q == OP_CSRXCHG) ? wb_rj_q : 32'hFFFF_FFFF;
        csr_wvalue      = wb_rd_q;
        wb_pc           = wb_pc_q;
        wb_vaddr        = wb_vaddr_q;
        wb_ecode        = commit_ex ? res_ecode : 6'd0;
        wb_esubcode     = commit_ex ? res_esubcode : 9'd0;
        rf_we           = wb_valid_q && !res_ex && (wb_dest_q != 5'd0) && wb_writes_gpr_op;
        rf_waddr        = wb_dest_q;
        rf_wdata        = wb_is_csr ? csr_rvalue : wb_result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            wb_valid_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            wb_valid_q    <= wb_valid_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wb_pc_q       <= in_pc;
            wb_op_q       <= in_op;
            wb_csr_num_q  <= in_csr_num;
            wb_rj_q       <= in_rj_value;
            wb_rd_q       <= in_rd_value;
            wb_dest_q     <= in_dest;
            wb_result_q   <= in_result;
            wb_ex_q       <= in_ex;
            wb_ecode_q    <= in_ecode;
            wb_esubcode_q <= in_esubcode;
            wb_vaddr_q    <= in_vaddr;
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            StIdle: begin
                if (wb_ex_with_ertn) begin
                    state_d       = StFlush;
                    redirect_pc_d = ex_entry;
                end
            end
            StFlush: begin
                if (redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready       = 1'b1;
        redirect_valid = (state_q == StFlush);
        redirect_pc    = redirect_pc_q;
    end

endmodule

// File: tb/tb_csr_commit_unit.sv
// Self-checking bench for csr_commit_unit: directed vector table, hand-written flush/reset
// sequences and randomized instructions checked against a behavioural model.
module tb_csr_commit_unit;

    typedef struct packed {
        logic [2:0]  op;
        logic [13:0] csr_num;
        logic [31:0] rj;
        logic [31:0] rd;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] vaddr;
        logic [31:0] pc;
        logic        has_int;
        logic [1:0]  plv;
        logic [31:0] rvalue;
        logic [31:0] entry;
    } stim_t;

    typedef struct packed {
        logic        csr_re;
        logic        csr_we;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ertn;
        logic        exert;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic        rf_we;
        logic [31:0] rf_wdata;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk, reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rj_value, in_rd_value, in_result, in_vaddr;
    logic [2:0]  in_op;
    logic [13:0] in_csr_num, csr_num;
    logic [4:0]  in_dest, rf_waddr;
    logic        in_ex;
    logic [5:0]  in_ecode, wb_ecode;
    logic [8:0]  in_esubcode, wb_esubcode;
    logic        csr_re, csr_we;
    logic [31:0] csr_wmask, csr_wvalue, csr_rvalue, ex_entry;
    logic        has_int;
    logic [1:0]  csr_plv;
    logic        ertn_flush, wb_ex_with_ertn;
    logic [31:0] wb_pc, wb_vaddr, rf_wdata, redirect_pc;
    logic        rf_we, redirect_valid, redirect_ready;

    int n_checks = 0;
    int n_fail   = 0;

    csr_commit_unit #(.CSR_NUM_WIDTH(14)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op(in_op), .in_csr_num(in_csr_num), .in_rj_value(in_rj_value),
        .in_rd_value(in_rd_value), .in_dest(in_dest), .in_result(in_result), .in_ex(in_ex),
        .in_ecode(in_ecode), .in_esubcode(in_esubcode), .in_vaddr(in_vaddr),
        .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue), .has_int(has_int),
        .csr_plv(csr_plv), .ex_entry(ex_entry), .ertn_flush(ertn_flush),
        .wb_ex_with_ertn(wb_ex_with_ertn), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour, straight from the commit rules.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic is_csr;
        e        = '0;
        is_csr   = s.op inside {3'd1, 3'd2, 3'd3};
        e.exert  = 1'b1;
        if (s.has_int)                              e.ecode = 6'h00;
        else if (s.ex)                              {e.ecode, e.esub} = {s.ecode, s.esub};
        else if ((is_csr || s.op == 3'd4) && s.plv != 0) e.ecode = 6'h0E;
        else if (s.op == 3'd5)                      e.ecode = 6'h0B;
        else if (s.op == 3'd6)                      e.ecode = 6'h0C;
        else                                        e.exert = 1'b0;
        if (!e.exert) begin
            e.csr_re = is_csr;
            e.csr_we = s.op inside {3'd2, 3'd3};
            e.ertn   = (s.op == 3'd4);
            e.exert  = e.ertn;
            e.rf_we  = (s.dest != 0) && !(s.op inside {3'd4, 3'd5, 3'd6});
        end
        e.wmask    = (s.op == 3'd3) ? s.rj : 32'hFFFF_FFFF;
        e.wvalue   = s.rd;
        e.rf_wdata = is_csr ? s.rvalue : s.result;
        return e;
    endfunction

    task automatic drive_in(input stim_t s);
        in_op = s.op; in_csr_num = s.csr_num; in_rj_value = s.rj; in_rd_value = s.rd;
        in_dest = s.dest; in_result = s.result; in_ex = s.ex; in_ecode = s.ecode;
        in_esubcode = s.esub; in_vaddr = s.vaddr; in_pc = s.pc;
    endtask

    task automatic set_env(input stim_t s);
        has_int = s.has_int; csr_plv = s.plv; csr_rvalue = s.rvalue; ex_entry = s.entry;
    endtask

    task automatic check_commit(input string tag, input stim_t s, input exp_t e);
        check({tag, " csr_re"}, 32'(csr_re), 32'(e.csr_re));
        check({tag, " csr_we"}, 32'(csr_we), 32'(e.csr_we));
        if (e.csr_re) check({tag, " csr_num"}, 32'(csr_num), 32'(s.csr_num));
        if (e.csr_we) begin
            check({tag, " wmask"}, csr_wmask, e.wmask);
            check({tag, " wvalue"}, csr_wvalue, e.wvalue);
        end
        check({tag, " ertn_flush"}, 32'(ertn_flush), 32'(e.ertn));
        check({tag, " ex_with_ertn"}, 32'(wb_ex_with_ertn), 32'(e.exert));
        check({tag, " ecode"}, 32'(wb_ecode), 32'(e.ecode));
        check({tag, " esubcode"}, 32'(wb_esubcode), 32'(e.esub));
        check({tag, " wb_pc"}, wb_pc, s.pc);
        check({tag, " wb_vaddr"}, wb_vaddr, s.vaddr);
        check({tag, " rf_we"}, 32'(rf_we), 32'(e.rf_we));
        if (e.rf_we) begin
            check({tag, " rf_waddr"}, 32'(rf_waddr), 32'(s.dest));
            check({tag, " rf_wdata"}, rf_wdata, e.rf_wdata);
        end
        check({tag, " redir_before"}, 32'(redirect_valid), 32'd0);
    endtask

    // One instruction: accept, check commit cycle, check/clear any redirect.
    task automatic run_instr(input string tag, input stim_t s, input exp_t e);
        @(negedge clk);
        drive_in(s);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        set_env(s);
        #1;
        check_commit(tag, s, e);
        @(posedge clk);
        #1;
        has_int = 1'b0;
        check({tag, " redir_valid"}, 32'(redirect_valid), 32'(e.exert));
        if (e.exert) begin
            check({tag, " redir_pc"}, redirect_pc, s.entry);
            redirect_ready = 1'b1;
            @(posedge clk);
            #1;
            redirect_ready = 1'b0;
            check({tag, " redir_release"}, 32'(redirect_valid), 32'd0);
        end
    endtask

    vec_t  vecs[$];
    stim_t s;
    exp_t  e;

    initial begin
        // op csr rj rd dest result ex ecode esub vaddr pc has_int plv rvalue entry
        // csr_re csr_we wmask wvalue ertn exert ecode esub rf_we rf_wdata
        vecs.push_back('{'{3'd3, 14'h30, 32'h0000_FF00, 32'h1234_5678, 5'd5, 32'h0, 1'b0,
            6'h0, 9'h0, 32'h0, 32'h1C00_1000, 1'b0, 2'd0, 32'hAAAA_AAAA, 32'h1C00_8000},
            '{1'b1, 1'b1, 32'h0000_FF00, 32'h1234_5678, 1'b0, 1'b0, 6'h00, 9'h0, 1'b1,
            32'hAAAA_AAAA}});
        vecs.push_back('{'{3'd2, 14'h5, 32'h0, 32'h1111_2222, 5'd4, 32'h0, 1'b0,
            6'h0, 9'h0, 32'h0, 32'h1C00_1004, 1'b0, 2'd3, 32'h3333_3333, 32'h1C00_8000},
            '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1111_2222, 1'b0, 1'b1, 6'h0E, 9'h0, 1'b0,
            32'h3333_3333}});
        vecs.push_back('{'{3'd5, 14'h0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0,
            6'h0, 9'h0, 32'h0, 32'h1C00_1008, 1'b1, 2'd0, 32'h0, 32'h1C00_4000},
            '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 6'h00, 9'h0, 1'b0, 32'h0}});
        vecs.push_back('{'{3'd4, 14'h0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0,
            6'h0, 9'h0, 32'h0, 32'h1C00_100C, 1'b0, 2'd0, 32'h0, 32'h1C00_0100},
            '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 6'h00, 9'h0, 1'b0, 32'h0}});
        vecs.push_back('{'{3'd0, 14'h0, 32'h0, 32'h0, 5'd7, 32'h55, 1'b1,
            6'h08, 9'h0, 32'h8000_0003, 32'h8000_0003, 1'b0, 2'd0, 32'h0, 32'h1C00_8000},
            '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 6'h08, 9'h0, 1'b0, 32'h55}});
        vecs.push_back('{'{3'd1, 14'h1, 32'h0, 32'h0, 5'd9, 32'h0, 1'b0,
            6'h0, 9'h0, 32'h0, 32'h1C00_1010, 1'b0, 2'd0, 32'h0000_5555, 32'h0},
            '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 6'h00, 9'h0, 1'b1,
            32'h0000_5555}});
        vecs.push_back('{'{3'd0, 14'h0, 32'h0, 32'h0, 5'd3, 32'hDEAD_BEEF, 1'b0,
            6'h0, 9'h0, 32'h0, 32'h1C00_1014, 1'b0, 2'd3, 32'h0, 32'h0},
            '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 6'h00, 9'h0, 1'b1,
            32'hDEAD_BEEF}});
        vecs.push_back('{'{3'd0, 14'h0, 32'h0, 32'h0, 5'd0, 32'h1234, 1'b0,
            6'h0, 9'h0, 32'h0, 32'h1C00_1018, 1'b0, 2'd0, 32'h0, 32'h0},
            '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 6'h00, 9'h0, 1'b0, 32'h1234}});
        vecs.push_back('{'{3'd6, 14'h0, 32'h0, 32'h0, 5'd2, 32'h0, 1'b0,
            6'h0, 9'h0, 32'h0, 32'h1C00_101C, 1'b0, 2'd0, 32'h0, 32'h1C00_2000},
            '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 6'h0C, 9'h0, 1'b0, 32'h0}});
        vecs.push_back('{'{3'd4, 14'h0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0,
            6'h0, 9'h0, 32'h0, 32'h1C00_1020, 1'b0, 2'd1, 32'h0, 32'h1C00_3000},
            '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 6'h0E, 9'h0, 1'b0, 32'h0}});
        vecs.push_back('{'{3'd2, 14'h2, 32'h0, 32'h0, 5'd8, 32'h0, 1'b1,
            6'h08, 9'h1, 32'h0000_0042, 32'h1C00_1024, 1'b0, 2'd3, 32'h0, 32'h1C00_5000},
            '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 6'h08, 9'h1, 1'b0, 32'h0}});

        reset = 1'b1; in_valid = 1'b0; redirect_ready = 1'b0;
        drive_in('0);
        set_env('0);
        repeat (2) @(posedge clk);
        #1;
        check("reset redirect_valid", 32'(redirect_valid), 32'd0);
        check("reset redirect_pc", redirect_pc, 32'd0);
        check("reset rf_we", 32'(rf_we), 32'd0);
        check("reset csr_re", 32'(csr_re), 32'd0);
        check("reset csr_we", 32'(csr_we), 32'd0);
        check("reset ex_with_ertn", 32'(wb_ex_with_ertn), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        foreach (vecs[i]) run_instr($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);

        // ERTN with redirect held off for three cycles while MEM keeps presenting.
        s = '0; s.op = 3'd4; s.pc = 32'h1C00_2000; s.entry = 32'h1C00_0100;
        @(negedge clk);
        drive_in(s);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        set_env(s);
        csr_rvalue = 32'h7777_0000;
        s.op = 3'd2; s.dest = 5'd6; s.rd = 32'hCAFE_0001; s.csr_num = 14'h6;
        drive_in(s);
        #1;
        check("hold ertn_flush", 32'(ertn_flush), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d redir_valid", c), 32'(redirect_valid), 32'd1);
            check($sformatf("hold%0d redir_pc", c), redirect_pc, 32'h1C00_0100);
            check($sformatf("hold%0d rf_we", c), 32'(rf_we), 32'd0);
            check($sformatf("hold%0d csr_we", c), 32'(csr_we), 32'd0);
        end
        redirect_ready = 1'b1;
        @(posedge clk);
        #1;
        redirect_ready = 1'b0;
        check("exit redir_valid", 32'(redirect_valid), 32'd0);
        check("exit dropped rf_we", 32'(rf_we), 32'd0);
        check("exit dropped csr_we", 32'(csr_we), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("resume csr_we", 32'(csr_we), 32'd1);
        check("resume rf_we", 32'(rf_we), 32'd1);
        check("resume rf_wdata", rf_wdata, 32'h7777_0000);
        @(posedge clk);
        #1;
        check("resume no redirect", 32'(redirect_valid), 32'd0);

        // Reset asserted while a SYSCALL redirect is pending.
        s = '0; s.op = 3'd5; s.entry = 32'h1C00_0C00;
        @(negedge clk);
        drive_in(s);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        set_env(s);
        @(posedge clk);
        #1;
        check("rstflush redir_valid", 32'(redirect_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rstflush cleared", 32'(redirect_valid), 32'd0);
        check("rstflush redir_pc", redirect_pc, 32'd0);
        s = '0; s.op = 3'd1; s.dest = 5'd11; s.rvalue = 32'h0BAD_F00D; s.csr_num = 14'h44;
        run_instr("after_rst", s, model(s));

        for (int i = 0; i < 300; i++) begin
            s.op      = 3'($urandom_range(0, 6));
            s.csr_num = 14'($urandom);
            s.rj      = $urandom;
            s.rd      = $urandom;
            s.dest    = 5'($urandom_range(0, 31));
            s.result  = $urandom;
            s.ex      = ($urandom_range(0, 7) == 0);
            s.ecode   = 6'($urandom);
            s.esub    = 9'($urandom);
            s.vaddr   = $urandom;
            s.pc      = $urandom;
            s.has_int = ($urandom_range(0, 7) == 0);
            s.plv     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            s.rvalue  = $urandom;
            s.entry   = $urandom;
            run_instr($sformatf("rnd%0d", i), s, model(s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_commit_unit.md
# csr_commit_unit

Write-back-stage CSR initiator for the LA32R pipeline. Accepts one instruction per cycle from MEM, resolves its final exception status (interrupt, upstream exception, privilege check), and drives the CSR file's access and exception-commit ports. It returns old CSR values to the register file. After any exception or ERTN commit, it holds a fetch redirect until fetch acknowledges it, discarding in-flight instructions meanwhile.

## Interface
Parameters:
- CSR_NUM_WIDTH, 14, CSR number width (shared constant)

Ports (one clock `clk`; `reset` is synchronous, active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  MEM has an instruction
- in_ready  out  1  unit accepts this cycle
- in_pc  in  32  instruction PC
- in_op  in  3  NONE/CSRRD/CSRWR/CSRXCHG/ERTN/SYSCALL/BREAK
- in_csr_num  in  14  CSR number
- in_rj_value  in  32  CSRXCHG write mask
- in_rd_value  in  32  CSR write data
- in_dest  in  5  destination GPR
- in_result  in  32  non-CSR result
- in_ex, in_ecode[6], in_esubcode[9], in_vaddr[32]  in  upstream exception info
- csr_re, csr_we  out  1  CSR read/write enable
- csr_num  out  14  CSR number
- csr_wmask, csr_wvalue  out  32  write mask/data
- csr_rvalue  in  32  old CSR value (combinational)
- has_int  in  1  pending enabled interrupt
- csr_plv  in  2  current privilege
- ex_entry  in  32  exception entry / ERA
- ertn_flush  out  1  ERTN commits
- wb_ex_with_ertn  out  1  exception or ERTN commits
- wb_pc, wb_vaddr  out  32;  wb_ecode  out  6;  wb_esubcode  out  9
- rf_we  out  1;  rf_waddr  out  5;  rf_wdata  out  32
- redirect_valid  out  1;  redirect_pc  out  32;  redirect_ready  in  1

## Operation
- WB register: captures the in_* fields when in_valid && in_ready && state==IDLE. wb_valid is cleared otherwise, so each instruction commits exactly once, in the cycle after acceptance.
- Exception resolution for a valid WB instruction, highest priority first:
  1. has_int → INT, ecode 0x00.
  2. in_ex → upstream ecode/esubcode.
  3. CSR op or ERTN with csr_plv≠0 → IPE, 0x0E.
  4. SYSCALL → SYS, 0x0B.
  5. BREAK → BRK, 0x0C.
  6. esubcode 0 for all except case 2.
- No exception:
  - CSRRD: csr_re=1, csr_we=0.
  - CSRWR: csr_re=1, csr_we=1, wmask=FFFF_FFFF, wvalue=rd_value.
  - CSRXCHG: csr_re=1, csr_we=1, wmask=rj_value, wvalue=rd_value.
  - ERTN: ertn_flush=1.
- Any exception: csr_re=csr_we=0, no GPR write.
- wb_ex_with_ertn = valid && (exception || ertn_flush). wb_pc=WB pc. wb_vaddr=WB vaddr.
- GPR write: rf_we = valid && !exception && dest≠0 && op∉{ERTN,SYSCALL,BREAK}. rf_wdata = csr_rvalue for CSR ops, else result.
- FSM:
  - IDLE: on a valid commit with wb_ex_with_ertn, latch redirect_pc←ex_entry and go to FLUSH.
  - FLUSH: redirect_valid=1, in_ready=1, inputs are dropped. On redirect_ready, go to IDLE.
- in_ready is 1 in both states; there is no backpressure.

## Timing
- Reset: state=IDLE, wb_valid=0, redirect_valid=0, redirect_pc=0. All CSR/RF strobes are 0.
- Latency: accept at edge N; CSR strobes, rf_we, and wb_* are valid during cycle N+1 and committed at edge N+1.
- redirect_valid rises the cycle after the exception/ERTN commit and stays high until the cycle redirect_ready is sampled high.
- ex_entry is sampled in the commit cycle, so ERTN redirects to the pre-commit ERA.
- has_int is sampled in the commit cycle only, so an interrupt arriving in FLUSH is taken on the next committed instruction.
- ERTN together with an exception → exception wins, ertn_flush=0.
- Instruction presented on the same edge that FLUSH exits → dropped; acceptance resumes the following cycle.
- Reset during FLUSH → IDLE, redirect dropped.

## Structure
- Shared package/header: ECODE_* values, ESUBCODE_ADEF, CSR_NUM_WIDTH, in_op encodings.
- One natural sub-module: `ex_resolve`, purely combinational priority resolution → {ex, ecode, esubcode}.
- FSM, WB register, and redirect latch stay in the top module.

## Test plan
- CSRXCHG at plv0, csr 0x30, rj=0x0000_FF00, rd=0x1234_5678, csr_rvalue=0xAAAA_AAAA → csr_we=1, wmask=0x0000_FF00, wvalue=0x1234_5678, rf_wdata=0xAAAA_AAAA, redirect_valid stays 0.
- CSRWR with csr_plv=3 → ecode=0x0E, csr_we=0, rf_we=0, wb_ex_with_ertn=1. Next cycle redirect_valid=1, redirect_pc=ex_entry (0x1C00_8000).
- SYSCALL with has_int=1 in the same cycle → ecode=0x00, not 0x0B.
- ERTN, ex_entry=0x1C00_0100 → ertn_flush=1, redirect_pc=0x1C00_0100. Hold redirect_ready=0 for 3 cycles with in_valid=1: no commits occur and redirect_valid stays high.
- Upstream ADE with esubcode 0, vaddr 0x8000_0003 → wb_ecode=0x08, wb_vaddr=0x8000_0003, no rf write.
- Assert reset while in FLUSH → next cycle redirect_valid=0 and the next instruction commits normally.
